// File: rtl/control_fsm.sv
// Multi-cycle control unit for the 16-bit stack machine.
// Drives datapath strobes from the FSM state and the current IR opcode.
module control_fsm (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [15:0] IROut,
    input  logic        isZero,
    output logic        PCSource,
    output logic        PCAdd,
    output logic        PCWrite,
    output logic        MSPWrite,
    output logic        MSPPop,
    output logic        RSPWrite,
    output logic        RSPPop,
    output logic        IRWrite,
    output logic        ValAWrite,
    output logic        ValBWrite,
    output logic        ResSource,
    output logic        ResWrite,
    output logic [1:0]  MemDst1,
    output logic [1:0]  MemDst2,
    output logic [2:0]  MemData,
    output logic        MemRead1,
    output logic        MemRead2,
    output logic        MemWrite1,
    output logic        MemWrite2,
    output logic [2:0]  ALUop,
    output logic        ShifterDir,
    output logic        ShifterMode
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_PUSHI = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h8;
    localparam logic [3:0] OP_STORE = 4'h9;
    localparam logic [3:0] OP_JMP   = 4'hA;
    localparam logic [3:0] OP_JZ    = 4'hB;
    localparam logic [3:0] OP_CALL  = 4'hC;
    localparam logic [3:0] OP_RET   = 4'hD;

    localparam logic [1:0] DST_PC   = 2'b00;
    localparam logic [1:0] DST_MSP  = 2'b01;
    localparam logic [1:0] DST_VALA = 2'b10;
    localparam logic [1:0] DST_RSP  = 2'b11;

    localparam logic [2:0] MD_RES  = 3'b000;
    localparam logic [2:0] MD_SEXT = 3'b001;
    localparam logic [2:0] MD_PC   = 3'b010;
    localparam logic [2:0] MD_VALB = 3'b011;
    localparam logic [2:0] MD_MEM1 = 3'b100;

    localparam logic [2:0] ALU_PASSA = 3'b111;

    typedef struct packed {
        logic       pcs;
        logic       pca;
        logic       pcw;
        logic       mspw;
        logic       mspp;
        logic       rspw;
        logic       rspp;
        logic       irw;
        logic       vaw;
        logic       vbw;
        logic       ress;
        logic       resw;
        logic [1:0] d1;
        logic [1:0] d2;
        logic [2:0] md;
        logic       mr1;
        logic       mr2;
        logic       mw1;
        logic       mw2;
        logic [2:0] alu;
        logic       sdir;
        logic       smode;
    } ctl_t;

    state_t     r_state;
    state_t     w_next;
    ctl_t       w_ctl;
    ctl_t       w_out;
    logic [3:0] w_op;
    logic       w_is_alu;
    logic       w_is_shf;
    logic       w_two_op;
    logic       w_is_nop;

    assign w_op     = IROut[15:12];
    assign w_is_alu = (w_op >= 4'h2) && (w_op <= 4'h5);
    assign w_is_shf = (w_op == 4'h6) || (w_op == 4'h7);
    assign w_two_op = ((w_op >= 4'h2) && (w_op <= 4'h9)) || (w_op == OP_JZ);
    assign w_is_nop = (w_op == OP_NOP) || (w_op == 4'hE) || (w_op == 4'hF);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH: w_next = S_DECODE;
            S_DECODE: begin
                if (w_is_nop) begin
                    w_next = S_FETCH;
                end else if (w_op == OP_PUSHI) begin
                    w_next = S_WB;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_is_alu || w_is_shf) begin
                    w_next = S_WB;
                end else if (w_op == OP_LOAD || w_op == OP_STORE) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_FETCH;
                end
            end
            S_MEM:   w_next = S_FETCH;
            S_WB:    w_next = S_FETCH;
            default: w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_ctl = '0;
        case (r_state)
            S_FETCH: begin
                w_ctl.mr1 = 1'b1;
                w_ctl.d1  = DST_PC;
                w_ctl.irw = 1'b1;
                w_ctl.pcw = 1'b1;
                w_ctl.pca = 1'b1;
            end
            S_DECODE: begin
                // Port 2 reads the entry below top; the memory applies the offset.
                if (w_two_op) begin
                    w_ctl.mr1 = 1'b1;
                    w_ctl.d1  = DST_MSP;
                    w_ctl.mr2 = 1'b1;
                    w_ctl.d2  = DST_MSP;
                    w_ctl.vaw = 1'b1;
                    w_ctl.vbw = 1'b1;
                end
            end
            S_EXEC: begin
                if (w_is_alu) begin
                    w_ctl.alu  = w_op[2:0] - 3'd2;
                    w_ctl.resw = 1'b1;
                    w_ctl.mspp = 1'b1;
                end else if (w_is_shf) begin
                    w_ctl.ress = 1'b1;
                    w_ctl.resw = 1'b1;
                    w_ctl.sdir = w_op[0];
                end else begin
                    case (w_op)
                        OP_LOAD: w_ctl.mspp = 1'b1;
                        OP_STORE: begin
                            w_ctl.mw1  = 1'b1;
                            w_ctl.d1   = DST_VALA;
                            w_ctl.md   = MD_VALB;
                            w_ctl.mspp = 1'b1;
                        end
                        OP_JMP: begin
                            w_ctl.pcw = 1'b1;
                            w_ctl.pcs = 1'b1;
                        end
                        OP_JZ: begin
                            w_ctl.alu  = ALU_PASSA;
                            w_ctl.mspp = 1'b1;
                            w_ctl.pcs  = 1'b1;
                            w_ctl.pcw  = isZero;
                        end
                        OP_CALL: begin
                            w_ctl.rspw = 1'b1;
                            w_ctl.mw2  = 1'b1;
                            w_ctl.d2   = DST_RSP;
                            w_ctl.md   = MD_PC;
                            w_ctl.pcw  = 1'b1;
                            w_ctl.pcs  = 1'b1;
                        end
                        OP_RET: begin
                            w_ctl.mr1  = 1'b1;
                            w_ctl.d1   = DST_RSP;
                            w_ctl.rspp = 1'b1;
                            w_ctl.pcw  = 1'b1;
                        end
                        default: w_ctl = '0;
                    endcase
                end
            end
            S_MEM: begin
                if (w_op == OP_LOAD) begin
                    w_ctl.mr1  = 1'b1;
                    w_ctl.d1   = DST_VALA;
                    w_ctl.mw2  = 1'b1;
                    w_ctl.d2   = DST_MSP;
                    w_ctl.md   = MD_MEM1;
                    w_ctl.mspw = 1'b1;
                end else if (w_op == OP_STORE) begin
                    w_ctl.mspp = 1'b1;
                end
            end
            S_WB: begin
                w_ctl.mw2 = 1'b1;
                w_ctl.d2  = DST_MSP;
                if (w_op == OP_PUSHI) begin
                    w_ctl.md   = MD_SEXT;
                    w_ctl.mspw = 1'b1;
                end else begin
                    w_ctl.md = MD_RES;
                end
            end
            default: w_ctl = '0;
        endcase
    end

    // Reset masks the strobes combinationally so they drop the instant RST_N falls.
    assign w_out = RST_N ? w_ctl : '0;

    assign PCSource    = w_out.pcs;
    assign PCAdd       = w_out.pca;
    assign PCWrite     = w_out.pcw;
    assign MSPWrite    = w_out.mspw;
    assign MSPPop      = w_out.mspp;
    assign RSPWrite    = w_out.rspw;
    assign RSPPop      = w_out.rspp;
    assign IRWrite     = w_out.irw;
    assign ValAWrite   = w_out.vaw;
    assign ValBWrite   = w_out.vbw;
    assign ResSource   = w_out.ress;
    assign ResWrite    = w_out.resw;
    assign MemDst1     = w_out.d1;
    assign MemDst2     = w_out.d2;
    assign MemData     = w_out.md;
    assign MemRead1    = w_out.mr1;
    assign MemRead2    = w_out.mr2;
    assign MemWrite1   = w_out.mw1;
    assign MemWrite2   = w_out.mw2;
    assign ALUop       = w_out.alu;
    assign ShifterDir  = w_out.sdir;
    assign ShifterMode = w_out.smode;

endmodule

// File: tb/tb_control_fsm.sv
// Scoreboard bench for control_fsm: per-cycle expected strobes are queued
// by the stimulus and popped by an independent monitor.
module tb_control_fsm;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [15:0] IROut;
    logic        isZero;
    logic        PCSource, PCAdd, PCWrite, MSPWrite, MSPPop;
    logic        RSPWrite, RSPPop, IRWrite, ValAWrite, ValBWrite;
    logic        ResSource, ResWrite;
    logic [1:0]  MemDst1, MemDst2;
    logic [2:0]  MemData;
    logic        MemRead1, MemRead2, MemWrite1, MemWrite2;
    logic [2:0]  ALUop;
    logic        ShifterDir, ShifterMode;

    control_fsm dut (
        .CLK(CLK), .RST_N(RST_N), .IROut(IROut), .isZero(isZero),
        .PCSource(PCSource), .PCAdd(PCAdd), .PCWrite(PCWrite),
        .MSPWrite(MSPWrite), .MSPPop(MSPPop),
        .RSPWrite(RSPWrite), .RSPPop(RSPPop),
        .IRWrite(IRWrite), .ValAWrite(ValAWrite), .ValBWrite(ValBWrite),
        .ResSource(ResSource), .ResWrite(ResWrite),
        .MemDst1(MemDst1), .MemDst2(MemDst2), .MemData(MemData),
        .MemRead1(MemRead1), .MemRead2(MemRead2),
        .MemWrite1(MemWrite1), .MemWrite2(MemWrite2),
        .ALUop(ALUop), .ShifterDir(ShifterDir), .ShifterMode(ShifterMode)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       pcs, pca, pcw, mspw, mspp, rspw, rspp;
        logic       irw, vaw, vbw, ress, resw;
        logic [1:0] d1;
        logic [1:0] d2;
        logic [2:0] md;
        logic       mr1, mr2, mw1, mw2;
        logic [2:0] alu;
        logic       sdir, smode;
    } ov_t;

    ov_t w_act;
    assign w_act = {PCSource, PCAdd, PCWrite, MSPWrite, MSPPop,
                    RSPWrite, RSPPop, IRWrite, ValAWrite, ValBWrite,
                    ResSource, ResWrite, MemDst1, MemDst2, MemData,
                    MemRead1, MemRead2, MemWrite1, MemWrite2,
                    ALUop, ShifterDir, ShifterMode};

    ov_t   q_exp[$];
    string q_name[$];
    int    checks;
    int    failures;
    event  e_samp;

    always begin
        @(negedge CLK or e_samp);
        if (q_exp.size() > 0) begin
            ov_t   e;
            string n;
            e = q_exp.pop_front();
            n = q_name.pop_front();
            checks++;
            if (w_act !== e) begin
                failures++;
                $display("FAIL %s: got %h expected %h", n, w_act, e);
            end
        end
    end

    task automatic step(input string n, input logic rst, input logic [15:0] ir,
                        input logic z, input ov_t e);
        @(posedge CLK);
        #1;
        RST_N  = rst;
        IROut  = ir;
        isZero = z;
        q_exp.push_back(e);
        q_name.push_back(n);
    endtask

    function automatic ov_t f_fetch();
        ov_t e = '0;
        e.mr1 = 1'b1; e.irw = 1'b1; e.pcw = 1'b1; e.pca = 1'b1;
        return e;
    endfunction

    function automatic ov_t f_dec2();
        ov_t e = '0;
        e.mr1 = 1'b1; e.d1 = 2'b01; e.mr2 = 1'b1; e.d2 = 2'b01;
        e.vaw = 1'b1; e.vbw = 1'b1;
        return e;
    endfunction

    function automatic ov_t f_wb(input logic push);
        ov_t e = '0;
        e.mw2 = 1'b1; e.d2 = 2'b01;
        e.md = push ? 3'b001 : 3'b000;
        e.mspw = push;
        return e;
    endfunction

    task automatic run_alu(input string n, input logic [15:0] ir, input logic [2:0] op);
        ov_t e = '0;
        e.alu = op; e.resw = 1'b1; e.mspp = 1'b1;
        step({n, "_F"}, 1'b1, ir, 1'b0, f_fetch());
        step({n, "_D"}, 1'b1, ir, 1'b0, f_dec2());
        step({n, "_E"}, 1'b1, ir, 1'b0, e);
        step({n, "_W"}, 1'b1, ir, 1'b0, f_wb(1'b0));
    endtask

    task automatic run_shf(input string n, input logic [15:0] ir, input logic dir);
        ov_t e = '0;
        e.ress = 1'b1; e.resw = 1'b1; e.sdir = dir;
        step({n, "_F"}, 1'b1, ir, 1'b0, f_fetch());
        step({n, "_D"}, 1'b1, ir, 1'b0, f_dec2());
        step({n, "_E"}, 1'b1, ir, 1'b0, e);
        step({n, "_W"}, 1'b1, ir, 1'b0, f_wb(1'b0));
    endtask

    task automatic run_jz(input string n, input logic z);
        ov_t e = '0;
        e.alu = 3'b111; e.mspp = 1'b1; e.pcs = 1'b1; e.pcw = z;
        step({n, "_F"}, 1'b1, 16'hB010, z, f_fetch());
        step({n, "_D"}, 1'b1, 16'hB010, z, f_dec2());
        step({n, "_E"}, 1'b1, 16'hB010, z, e);
    endtask

    task automatic run_nop(input string n, input logic [15:0] ir);
        step({n, "_F"}, 1'b1, ir, 1'b0, f_fetch());
        step({n, "_D"}, 1'b1, ir, 1'b0, '0);
    endtask

    initial begin
        ov_t e;
        checks   = 0;
        failures = 0;
        RST_N    = 1'b0;
        IROut    = 16'h0000;
        isZero   = 1'b0;

        step("reset", 1'b0, 16'h0000, 1'b0, '0);

        run_alu("add", 16'h2000, 3'b000);

        step("pushi_F", 1'b1, 16'h1FFF, 1'b0, f_fetch());
        step("pushi_D", 1'b1, 16'h1FFF, 1'b0, '0);
        step("pushi_W", 1'b1, 16'h1FFF, 1'b0, f_wb(1'b1));

        run_alu("sub", 16'h3000, 3'b001);
        run_alu("and", 16'h4abc, 3'b010);
        run_alu("or",  16'h5001, 3'b011);
        run_shf("shl", 16'h6000, 1'b0);
        run_shf("shr", 16'h7003, 1'b1);

        step("load_F", 1'b1, 16'h8000, 1'b0, f_fetch());
        step("load_D", 1'b1, 16'h8000, 1'b0, f_dec2());
        e = '0; e.mspp = 1'b1;
        step("load_E", 1'b1, 16'h8000, 1'b0, e);
        e = '0; e.mr1 = 1'b1; e.d1 = 2'b10; e.mw2 = 1'b1; e.d2 = 2'b01;
        e.md = 3'b100; e.mspw = 1'b1;
        step("load_M", 1'b1, 16'h8000, 1'b0, e);

        step("store_F", 1'b1, 16'h9000, 1'b0, f_fetch());
        step("store_D", 1'b1, 16'h9000, 1'b0, f_dec2());
        e = '0; e.mw1 = 1'b1; e.d1 = 2'b10; e.md = 3'b011; e.mspp = 1'b1;
        step("store_E", 1'b1, 16'h9000, 1'b0, e);
        e = '0; e.mspp = 1'b1;
        step("store_M", 1'b1, 16'h9000, 1'b0, e);

        step("jmp_F", 1'b1, 16'hA123, 1'b0, f_fetch());
        step("jmp_D", 1'b1, 16'hA123, 1'b0, '0);
        e = '0; e.pcw = 1'b1; e.pcs = 1'b1;
        step("jmp_E", 1'b1, 16'hA123, 1'b0, e);

        run_jz("jz1", 1'b1);
        run_jz("jz0", 1'b0);

        step("call_F", 1'b1, 16'hC020, 1'b0, f_fetch());
        step("call_D", 1'b1, 16'hC020, 1'b0, '0);
        e = '0; e.rspw = 1'b1; e.mw2 = 1'b1; e.d2 = 2'b11; e.md = 3'b010;
        e.pcw = 1'b1; e.pcs = 1'b1;
        step("call_E", 1'b1, 16'hC020, 1'b0, e);

        step("ret_F", 1'b1, 16'hD000, 1'b0, f_fetch());
        step("ret_D", 1'b1, 16'hD000, 1'b0, '0);
        e = '0; e.mr1 = 1'b1; e.d1 = 2'b11; e.rspp = 1'b1; e.pcw = 1'b1;
        step("ret_E", 1'b1, 16'hD000, 1'b0, e);

        run_nop("opF", 16'hF123);
        run_nop("opE", 16'hE000);
        run_nop("nop", 16'h0000);

        step("mid_F", 1'b1, 16'h2000, 1'b0, f_fetch());
        step("mid_D", 1'b1, 16'h2000, 1'b0, f_dec2());
        e = '0; e.alu = 3'b000; e.resw = 1'b1; e.mspp = 1'b1;
        step("mid_E", 1'b1, 16'h2000, 1'b0, e);
        #5;
        RST_N = 1'b0;
        #1;
        q_exp.push_back('0);
        q_name.push_back("rst_async");
        -> e_samp;
        step("rst_hold", 1'b0, 16'h2000, 1'b0, '0);
        step("rel_F", 1'b1, 16'h2000, 1'b0, f_fetch());
        step("rel_D", 1'b1, 16'h2000, 1'b0, f_dec2());
        step("rel_E", 1'b1, 16'h2000, 1'b0, e);
        step("rel_W", 1'b1, 16'h2000, 1'b0, f_wb(1'b0));
        step("end_F", 1'b1, 16'h0000, 1'b0, f_fetch());

        @(posedge CLK);
        #1;
        checks++;
        if (q_exp.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", q_exp.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
CONTROL_FSM -- requirements
Module: control_fsm

Interface
REQ-001 Clock and reset SHALL be one clock and an asynchronous, active-low reset.
REQ-002 CLK  input  1  rising-edge clock.
REQ-003 RST_N  input  1  async active-low reset.
REQ-004 IROut  input  16  current IR; [15:12] opcode, [11:0] immediate.
REQ-005 isZero  input  1  ALU result-zero flag.
REQ-006 PCSource, PCAdd  output  1 each  next-PC select: PCAdd=1 -> PC+1; else PCSource=1 -> ZeroExt, PCSource=0 -> MemOut1.
REQ-007 PCWrite  output  1  PC load enable.
REQ-008 MSPWrite, MSPPop  output  1 each  main stack push / pop.
REQ-009 RSPWrite, RSPPop  output  1 each  return stack push / pop.
REQ-010 IRWrite, ValAWrite, ValBWrite  output  1 each  register load enables.
REQ-011 ResSource  output  1  0=ALU, 1=shifter; ResWrite  output  1  Res load enable.
REQ-012 MemDst1, MemDst2  output  2 each  address select: 00 PC, 01 MSP, 10 ValA, 11 RSP.
REQ-013 MemData  output  3  write-data select: 000 Res, 001 SignExt, 010 PC, 011 ValB, 100 MemOut1.
REQ-014 MemRead1, MemRead2, MemWrite1, MemWrite2  output  1 each  port strobes.
REQ-015 ALUop  output  3  000 add, 001 sub, 010 and, 011 or, 111 pass A.
REQ-016 ShifterDir, ShifterMode  output  1 each  0 left / 1 right; 0 logical.

Function
REQ-017 Five states SHALL be implemented: FETCH, DECODE, EXEC, MEM, WB; outputs SHALL be decoded from state and IROut; every unlisted output SHALL be 0.
REQ-018 Opcodes SHALL be: 0 NOP, 1 PUSHI, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 SHL, 7 SHR, 8 LOAD, 9 STORE, A JMP, B JZ, C CALL, D RET; E and F SHALL execute as NOP.
REQ-019 FETCH: MemRead1=1, MemDst1=00, IRWrite=1, PCWrite=1, PCAdd=1; next state DECODE.
REQ-020 DECODE: opcodes 2-9 and B SHALL assert MemRead1 (Dst1=01), MemRead2 (Dst2 = 01 with port-2 top-1 offset), ValAWrite and ValBWrite; NOP/E/F -> FETCH, PUSHI -> WB, all others -> EXEC.
REQ-021 EXEC ADD/SUB/AND/OR: ALUop = opcode-2, ResSource=0, ResWrite=1, MSPPop=1; next state WB.
REQ-022 EXEC SHL/SHR: ResSource=1, ResWrite=1, ShifterDir = opcode[0], ShifterMode=0; no pop; next state WB.
REQ-023 WB: MemWrite2=1, MemDst2=01; MemData=001 with MSPWrite=1 for PUSHI, else MemData=000 (overwrite top); next state FETCH.
REQ-024 LOAD: EXEC MSPPop=1 -> MEM; MEM MemRead1 (Dst1=10), MemWrite2 (Dst2=01), MemData=100, MSPWrite=1 -> FETCH.
REQ-025 STORE: EXEC MemWrite1 (Dst1=10), MemData=011, MSPPop=1 -> MEM; MEM MSPPop=1 -> FETCH (net two pops).
REQ-026 JMP: EXEC PCWrite=1, PCSource=1 -> FETCH.
REQ-027 JZ: EXEC ALUop=111, MSPPop=1, PCSource=1, PCWrite=isZero (sampled same cycle) -> FETCH.
REQ-028 CALL: EXEC RSPWrite=1, MemWrite2=1 (Dst2=11), MemData=010, PCWrite=1, PCSource=1 -> FETCH.
REQ-029 RET: EXEC MemRead1 (Dst1=11), RSPPop=1, PCWrite=1, PCAdd=0, PCSource=0 -> FETCH.
REQ-030 Latency in cycles: NOP 2; PUSHI, JMP, JZ, CALL, RET 3; ALU, shift, LOAD, STORE 4.
REQ-031 IRWrite SHALL assert only in FETCH; IROut SHALL be treated as stable from DECODE through the end of the instruction.
REQ-032 The state register SHALL never hold an unencoded value; any illegal encoding SHALL recover to FETCH on the next edge.

Reset
REQ-033 RST_N=0 SHALL asynchronously force state to FETCH and every output to 0 while asserted, including mid-instruction.
REQ-034 On the first rising CLK edge after RST_N deasserts, FETCH outputs SHALL be active.

Verification
REQ-035 Reset pulse mid-EXEC of ADD -> all outputs 0 immediately; after release FETCH shows IRWrite=1, PCAdd=1.
REQ-036 IROut=16'h2000 (ADD) -> states F,D,E,W; EXEC ALUop=000, MSPPop=1; WB MemWrite2=1, MemData=000.
REQ-037 IROut=16'h1FFF (PUSHI) -> F,D,W; WB MSPWrite=1, MemData=001.
REQ-038 IROut=16'hB010 (JZ): isZero=1 -> PCWrite=1, PCSource=1 in EXEC; isZero=0 -> PCWrite=0; both return to FETCH.
REQ-039 IROut=16'hC020 (CALL) then 16'hD000 (RET) -> CALL EXEC RSPWrite=1, MemData=010; RET EXEC RSPPop=1, PCAdd=0, PCSource=0.
REQ-040 IROut=16'hF123 -> F,D,F; no write strobes asserted in DECODE.
